// File: rtl/csr_file.sv
// Machine-mode CSR unit: combinational CSR read/decode, clock-edge read-modify-write,
// 64-bit cycle/instret counters, trap entry / mret state and interrupt-pending detection.
module csr_file #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en,
  input  logic [2:0]  csr_funct,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_uimm,
  input  logic [31:0] csr_rs1,
  output logic [31:0] csr_rd_data,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mstatus_val, mip_val, rd_val, src, wdata, tvec_base;
  logic        addr_ok, addr_ro, wr_req, wr_en;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  // Address decode: old value, whether the address exists, whether it is read-only
  always_comb begin
    rd_val  = '0;
    addr_ok = 1'b1;
    addr_ro = (csr_addr[11:10] == 2'b11);
    case (csr_addr)
      A_MSTATUS:              rd_val = mstatus_val;
      A_MISA:      begin      rd_val = MISA_VAL; addr_ro = 1'b1; end
      A_MIE:                  rd_val = mie_q;
      A_MTVEC:                rd_val = mtvec_q;
      A_MSCRATCH:             rd_val = mscratch_q;
      A_MEPC:                 rd_val = mepc_q;
      A_MCAUSE:               rd_val = mcause_q;
      A_MTVAL:                rd_val = mtval_q;
      A_MIP:       begin      rd_val = mip_val; addr_ro = 1'b1; end
      A_MCYCLE,    A_CYCLE:    rd_val = mcycle_q[31:0];
      A_MCYCLEH,   A_CYCLEH:   rd_val = mcycle_q[63:32];
      A_MINSTRET,  A_INSTRET:  rd_val = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: rd_val = minstret_q[63:32];
      A_MHARTID:              rd_val = HART_ID;
      default:                addr_ok = 1'b0;
    endcase
  end

  assign src = csr_funct[2] ? {27'b0, csr_uimm} : csr_rs1;

  // Set/clear with a zero operand is a pure read and must not fault on read-only CSRs
  assign wr_req = csr_en & ~trap_req &
                  ((csr_funct[1:0] == 2'b01) | (csr_funct[1] & (csr_uimm != 5'd0)));
  assign csr_illegal = csr_en & (~addr_ok | (wr_req & addr_ro));
  assign wr_en       = wr_req & ~csr_illegal & ~mret;
  assign csr_rd_data = csr_illegal ? 32'd0 : rd_val;

  always_comb begin
    case (csr_funct[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = rd_val | src;
      2'b11:   wdata = rd_val & ~src;
      default: wdata = rd_val;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'b0, instr_retire & ~trap_req};

    // A written half replaces that cycle's increment; the other half holds
    if (wr_en) begin
      case (csr_addr)
        A_MSTATUS:   begin mstatus_mie_d = wdata[3]; mstatus_mpie_d = wdata[7]; end
        A_MIE:       mie_d      = wdata & MIE_MASK;
        A_MTVEC:     mtvec_d    = {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
        A_MSCRATCH:  mscratch_d = wdata;
        A_MEPC:      mepc_d     = {wdata[31:2], 2'b00};
        A_MCAUSE:    mcause_d   = wdata;
        A_MTVAL:     mtval_d    = wdata;
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        A_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        A_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (trap_req) begin
      mepc_d         = {trap_pc[31:2], 2'b00};
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Vectored mode only applies to interrupts (cause MSB set)
  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[31]) ?
                       tvec_base + {25'b0, trap_cause[4:0], 2'b00} : tvec_base;
  assign mepc_out    = mepc_q;
  assign irq_pending = mstatus_mie_q & (|(mie_q & mip_val));

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus a randomized run against a
// behavioural model of the machine-mode CSR map.
module tb_csr_file;
  localparam logic [31:0] HART_ID   = 32'd0;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;

  logic clk, reset, csr_en, csr_illegal, instr_retire, trap_req, mret;
  logic irq_ext, irq_timer, irq_sw, irq_pending;
  logic [2:0]  csr_funct;
  logic [11:0] csr_addr;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_rs1, csr_rd_data, trap_cause, trap_pc, trap_val, trap_vector, mepc_out;

  csr_file #(.HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST)) dut (
    .clk(clk), .reset(reset), .csr_en(csr_en), .csr_funct(csr_funct), .csr_addr(csr_addr),
    .csr_uimm(csr_uimm), .csr_rs1(csr_rs1), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret(mret), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  function automatic void m_read(input logic [11:0] a, output bit ok, output bit ro,
                                 output logic [31:0] v);
    ok = 1'b1;
    ro = (a >= 12'hC00);
    v  = 32'd0;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
      12'h304: v = m_mier;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin
        v  = (irq_ext ? 32'h800 : 0) + (irq_timer ? 32'h80 : 0) + (irq_sw ? 32'h8 : 0);
        ro = 1'b1;
      end
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF14: v = HART_ID;
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic bit m_writes();
    return csr_en && !trap_req &&
           (csr_funct == 3'd1 || csr_funct == 3'd5 || (csr_funct != 3'd4 && csr_funct[1] && csr_uimm != 0));
  endfunction

  function automatic bit m_illegal();
    bit ok, ro; logic [31:0] v;
    m_read(csr_addr, ok, ro, v);
    return csr_en && (!ok || (m_writes() && ro));
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] base = m_mtvec - (m_mtvec % 4);
    if (m_mtvec % 4 == 1 && trap_cause[31]) return base + 4 * (trap_cause % 32);
    return base;
  endfunction

  function automatic bit m_irq();
    bit ok, ro; logic [31:0] mip;
    m_read(12'h344, ok, ro, mip);
    return m_mie && ((m_mier & mip) != 0);
  endfunction

  // Advance one clock and move the model forward with the inputs held across the edge
  task automatic tick();
    bit ok, ro, do_wr;
    logic [31:0] old, src, nv;
    logic [63:0] ncyc, nins;
    @(posedge clk);
    if (!reset) begin
      m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    end else begin
      m_read(csr_addr, ok, ro, old);
      src   = csr_funct[2] ? 32'(csr_uimm) : csr_rs1;
      do_wr = m_writes() && !m_illegal() && !mret;
      case (csr_funct)
        3'd1, 3'd5: nv = src;
        3'd2, 3'd6: nv = old | src;
        3'd3, 3'd7: nv = old & ~src;
        default:    nv = old;
      endcase
      ncyc = m_cyc + 1;
      nins = m_ins + ((instr_retire && !trap_req) ? 1 : 0);
      if (do_wr) begin
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mier = nv & 32'h888;
          12'h305: m_mtvec = (nv % 4 >= 2) ? nv - (nv % 4) : nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv - (nv % 4);
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: ncyc = (m_cyc & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
          12'hB80: ncyc = (64'(nv) << 32) | (m_cyc & 64'h0000_0000_FFFF_FFFF);
          12'hB02: nins = (m_ins & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
          12'hB82: nins = (64'(nv) << 32) | (m_ins & 64'h0000_0000_FFFF_FFFF);
          default: ;
        endcase
      end
      if (trap_req) begin
        m_mepc = trap_pc - (trap_pc % 4); m_mcause = trap_cause; m_mtval = trap_val;
        m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end
      m_cyc = ncyc; m_ins = nins;
    end
    #1;
  endtask

  task automatic idle();
    csr_en = 0; csr_funct = 0; csr_addr = 0; csr_uimm = 0; csr_rs1 = 0;
    instr_retire = 0; trap_req = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0;
  endtask

  task automatic csr(input logic [2:0] f, input logic [11:0] a, input logic [4:0] u,
                     input logic [31:0] r);
    idle();
    csr_en = 1; csr_funct = f; csr_addr = a; csr_uimm = u; csr_rs1 = r;
  endtask

  task automatic test_reset();
    reset = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0; idle();
    tick(); tick();
    reset = 1; #1;
    n_vec++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq_pending); end
    n_vec++; if (trap_vector !== MTVEC_RST) begin n_err++; $display("FAIL rst_tvec: got %h want %h", trap_vector, MTVEC_RST); end
    n_vec++; if (mepc_out !== 32'h0) begin n_err++; $display("FAIL rst_mepc: got %h want 0", mepc_out); end
    repeat (5) tick();
    csr(3'b010, 12'hB00, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'd5) begin n_err++; $display("FAIL rst_mcycle: got %h want 5", csr_rd_data); end
    n_vec++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL rst_mcycle_ill: got %b want 0", csr_illegal); end
    tick();
    csr(3'b010, 12'h300, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h1800) begin n_err++; $display("FAIL rst_mstatus: got %h want 1800", csr_rd_data); end
    tick();
  endtask

  task automatic test_rw_rs_rc();
    csr(3'b001, 12'h340, 5'd0, 32'hDEADBEEF); #1;
    n_vec++; if (csr_rd_data !== 32'h0) begin n_err++; $display("FAIL rw_old: got %h want 0", csr_rd_data); end
    tick();
    csr(3'b010, 12'h340, 5'd0, 32'hFFFFFFFF); #1;
    n_vec++; if (csr_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rs0_read: got %h want deadbeef", csr_rd_data); end
    tick();
    csr(3'b111, 12'h340, 5'h0F, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rci_old: got %h want deadbeef", csr_rd_data); end
    tick();
    csr(3'b010, 12'h340, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'hDEADBEE0) begin n_err++; $display("FAIL rci_new: got %h want deadbee0", csr_rd_data); end
    tick();
  endtask

  task automatic test_trap();
    csr(3'b001, 12'h305, 5'd0, 32'h101); tick();
    csr(3'b001, 12'h300, 5'd0, 32'h8); tick();
    idle(); trap_req = 1; trap_cause = 32'h80000007; trap_pc = 32'h206; trap_val = 32'h55; #1;
    n_vec++; if (trap_vector !== 32'h11C) begin n_err++; $display("FAIL trap_vec: got %h want 0000011c", trap_vector); end
    tick();
    csr(3'b010, 12'h342, 5'd0, 32'h0); #1;
    n_vec++; if (mepc_out !== 32'h204) begin n_err++; $display("FAIL trap_mepc: got %h want 204", mepc_out); end
    n_vec++; if (csr_rd_data !== 32'h80000007) begin n_err++; $display("FAIL trap_mcause: got %h want 80000007", csr_rd_data); end
    tick();
    csr(3'b010, 12'h343, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h55) begin n_err++; $display("FAIL trap_mtval: got %h want 55", csr_rd_data); end
    tick();
    csr(3'b010, 12'h300, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h1880) begin n_err++; $display("FAIL trap_mstatus: got %h want 1880", csr_rd_data); end
    tick();
    idle(); mret = 1; tick();
    csr(3'b010, 12'h300, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus: got %h want 1888", csr_rd_data); end
    tick();
  endtask

  task automatic test_illegal();
    csr(3'b001, 12'hC00, 5'd0, 32'h123); #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL ill_cycle: got %b want 1", csr_illegal); end
    n_vec++; if (csr_rd_data !== 32'h0) begin n_err++; $display("FAIL ill_cycle_rd: got %h want 0", csr_rd_data); end
    tick();
    csr(3'b001, 12'hF14, 5'd0, 32'h77); #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL ill_hartid: got %b want 1", csr_illegal); end
    tick();
    csr(3'b010, 12'h7C0, 5'd0, 32'h0); #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL ill_unknown: got %b want 1", csr_illegal); end
    n_vec++; if (csr_rd_data !== 32'h0) begin n_err++; $display("FAIL ill_unknown_rd: got %h want 0", csr_rd_data); end
    tick();
    csr(3'b110, 12'h301, 5'd1, 32'h0); #1;
    n_vec++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL ill_misa_rsi: got %b want 1", csr_illegal); end
    tick();
    csr(3'b010, 12'h301, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h40000100 || csr_illegal !== 1'b0) begin n_err++; $display("FAIL misa_read: got %h/%b want 40000100/0", csr_rd_data, csr_illegal); end
    tick();
    csr(3'b010, 12'hC00, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== m_cyc[31:0]) begin n_err++; $display("FAIL cycle_alias: got %h want %h", csr_rd_data, m_cyc[31:0]); end
    tick();
  endtask

  task automatic test_counters();
    csr(3'b001, 12'hB80, 5'd0, 32'h0); tick();
    csr(3'b001, 12'hB00, 5'd0, 32'hFFFFFFFF); tick();
    csr(3'b010, 12'hB80, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h0) begin n_err++; $display("FAIL wrap_hi0: got %h want 0", csr_rd_data); end
    tick();
    csr(3'b010, 12'hB00, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h0) begin n_err++; $display("FAIL wrap_lo: got %h want 0", csr_rd_data); end
    tick();
    csr(3'b010, 12'hB80, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h1) begin n_err++; $display("FAIL wrap_hi1: got %h want 1", csr_rd_data); end
    tick();
    csr(3'b001, 12'h340, 5'd0, 32'h12345678); trap_req = 1; trap_cause = 32'h2; trap_pc = 32'h300; tick();
    csr(3'b010, 12'h340, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'hDEADBEE0) begin n_err++; $display("FAIL trap_drops_wr: got %h want deadbee0", csr_rd_data); end
    tick();
    csr(3'b001, 12'hB02, 5'd0, 32'h0); tick();
    idle(); instr_retire = 1; repeat (3) tick();
    trap_req = 1; tick();
    csr(3'b010, 12'hB02, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'd3) begin n_err++; $display("FAIL minstret: got %h want 3", csr_rd_data); end
    tick();
  endtask

  task automatic test_irq();
    csr(3'b001, 12'h304, 5'd0, 32'h80); tick();
    csr(3'b001, 12'h300, 5'd0, 32'h8); tick();
    idle(); irq_timer = 1; #1;
    n_vec++; if (irq_pending !== 1'b1) begin n_err++; $display("FAIL irq_on: got %b want 1", irq_pending); end
    csr(3'b010, 12'h344, 5'd0, 32'h0); #1;
    n_vec++; if (csr_rd_data !== 32'h80) begin n_err++; $display("FAIL mip_read: got %h want 80", csr_rd_data); end
    tick();
    csr(3'b111, 12'h300, 5'd8, 32'h0); tick();
    idle(); #1;
    n_vec++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL irq_off: got %b want 0", irq_pending); end
    irq_timer = 0;
  endtask

  task automatic test_random();
    logic [11:0] addrs[21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                               12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h345, 12'h000};
    logic [2:0] functs[6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    bit ok, ro, ill;
    logic [31:0] old, exp_rd;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 63) != 0);
      csr_en       = ($urandom_range(0, 3) != 0);
      csr_funct    = functs[$urandom_range(0, 5)];
      csr_addr     = addrs[$urandom_range(0, 20)];
      csr_uimm     = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      csr_rs1      = $urandom;
      instr_retire = 1'($urandom);
      trap_req     = ($urandom_range(0, 15) == 0);
      trap_cause   = $urandom;
      trap_pc      = $urandom;
      trap_val     = $urandom;
      mret         = ($urandom_range(0, 15) == 0);
      irq_ext      = 1'($urandom);
      irq_timer    = 1'($urandom);
      irq_sw       = 1'($urandom);
      #1;
      m_read(csr_addr, ok, ro, old);
      ill    = m_illegal();
      exp_rd = ill ? 32'h0 : old;
      n_vec++; if (csr_illegal !== ill) begin n_err++; $display("FAIL rnd_ill[%0d]: got %b want %b", i, csr_illegal, ill); end
      n_vec++; if (csr_rd_data !== exp_rd) begin n_err++; $display("FAIL rnd_rd[%0d] addr %h: got %h want %h", i, csr_addr, csr_rd_data, exp_rd); end
      n_vec++; if (trap_vector !== m_tvec()) begin n_err++; $display("FAIL rnd_tvec[%0d]: got %h want %h", i, trap_vector, m_tvec()); end
      n_vec++; if (mepc_out !== m_mepc) begin n_err++; $display("FAIL rnd_mepc[%0d]: got %h want %h", i, mepc_out, m_mepc); end
      n_vec++; if (irq_pending !== m_irq()) begin n_err++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq_pending, m_irq()); end
      tick();
    end
    reset = 1; idle();
  endtask

  initial begin
    test_reset();
    test_rw_rs_rc();
    test_trap();
    test_illegal();
    test_counters();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR unit on the core's CSR port, directly downstream of the single-cycle datapath.
- Decodes `csr_addr` and returns the old CSR value combinationally on `csr_rd_data` for the writeback mux.
- Performs the CSRRW/RS/RC (and immediate) read-modify-write at the clock edge.
- Maintains the 64-bit cycle/instret counters, trap entry/mret state and interrupt-pending detection for the PC control logic.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- csr_en  in  1  current instruction is a CSR op
- csr_funct  in  3  instr[14:12]: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr  in  12  instr[31:20]
- csr_uimm  in  5  instr[19:15] (rs1 index or zimm)
- csr_rs1  in  32  rs1 register value
- csr_rd_data  out  32  old CSR value (combinational)
- csr_illegal  out  1  unimplemented address, or write to read-only CSR
- instr_retire  in  1  an instruction completes this cycle
- trap_req  in  1  one-cycle trap request
- trap_cause  in  32  mcause value
- trap_pc  in  32  PC of the trapping instruction
- trap_val  in  32  mtval value
- mret  in  1  MRET executing
- irq_ext, irq_timer, irq_sw  in  1 each  level interrupt inputs
- trap_vector  out  32  trap target PC
- mepc_out  out  32  mret target PC
- irq_pending  out  1  interrupt should be taken

Behaviour:
- Register map (writable unless noted):
  - mstatus 0x300: MIE bit3, MPIE bit7; MPP[12:11] hardwired 11; all other bits read 0.
  - misa 0x301: read-only, 0x40000100.
  - mie 0x304: bits 3, 7, 11 only.
  - mtvec 0x305: MODE[1:0], where 10/11 are written as 00.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342; mtval 0x343.
  - mip 0x344: read-only; bit11 = irq_ext, bit7 = irq_timer, bit3 = irq_sw.
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases.
  - mhartid 0xF14: read-only.
- Reset values:
  - mstatus = 0x00001800; mtvec = MTVEC_RST; all other storage 0.
  - Outputs follow from stored state after reset: irq_pending = 0; trap_vector = MTVEC_RST base.
- Source operand: src = csr_rs1 for funct[2] = 0, else {27'b0, csr_uimm}.
- New value written:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Write enable: csr_en & ~csr_illegal & ~trap_req & ~(op is RS/RC & csr_uimm == 0). RW always writes.
- csr_illegal (combinational, csr_en only):
  - address not in the map → illegal;
  - write enable would be set and address is read-only (csr_addr[11:10] == 11, or misa/mip) → illegal.
  - On illegal: no state change; csr_rd_data = 0.
- Counters:
  - mcycle increments every cycle after reset.
  - minstret increments when instr_retire & ~trap_req.
  - A CSR write to either 32-bit half overrides that cycle's increment. The written half takes the new value; the other half holds (no carry into it).
- Trap entry (trap_req = 1, at clock edge):
  - mepc ← trap_pc & ~3; mcause ← trap_cause; mtval ← trap_val;
  - MPIE ← MIE; MIE ← 0.
  - Concurrent CSR write and mret are discarded.
- mret (no trap_req): MIE ← MPIE; MPIE ← 1. A CSR write in the same cycle is discarded.
- trap_vector (combinational):
  - base = {mtvec[31:2], 2'b00}.
  - If MODE == 01 and trap_cause[31] == 1: base + (trap_cause[4:0] << 2); otherwise base.
- mepc_out = mepc.
- irq_pending = MIE & |(mie & mip).
- Reset asserted mid-operation: all state returns to reset values on that edge; a pending write or trap is lost.
- Latency: reads 0 cycles; write visible on the read path the next cycle.

Test Plan:
- Reset release then 5 idle cycles → read mcycle (csrrs x0) returns 5. No write occurs: uimm = 0, so csr_illegal = 0.
- CSRRW mscratch with rs1 = 0xDEADBEEF, then CSRRS with uimm = 0 → rd_data 0xDEADBEEF, value unchanged. Next, CSRRCI uimm = 0x0F → 0xDEADBEE0.
- mtvec = 0x00000101, trap_req with cause 0x80000007, pc 0x00000206, MIE = 1 → trap_vector = 0x0000011C (combinational, during the trap_req cycle). After the edge: mepc = 0x204, mcause = 0x80000007, MIE = 0, MPIE = 1. Then mret → MIE = 1.
- CSRRW to cycle (0xC00) or mhartid → csr_illegal = 1, no state change. Unknown address 0x7C0 → csr_illegal = 1, rd_data = 0.
- Write mcycle = 0xFFFFFFFF with mcycleh = 0 → next cycle mcycleh = 1, mcycle = 0. Same-cycle trap_req and CSRRW mscratch → mscratch unchanged.
- mie = 0x80, MIE = 1, raise irq_timer → irq_pending = 1. Lower MIE → irq_pending = 0.
